// File: rtl/rf_wb_sched.sv
// Register-file write-port scheduler: WB stage vs. a 2-entry multi-cycle result buffer.
// The optional hazard scoreboard is built only when RF_WB_SCOREBOARD_EN is defined.
module rf_wb_sched #(
    parameter int STARVE_MAX = 3,
    parameter int MAX_OUT    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_wr,
    input  logic [31:0] pipe_wd,
    output logic        pipe_hold,
    input  logic        mc_issue,
    input  logic [4:0]  mc_rd,
    output logic        mc_issue_ok,
    input  logic        mc_valid,
    output logic        mc_ready,
    input  logic [4:0]  mc_wr,
    input  logic [31:0] mc_wd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    output logic        busy_rs1,
    output logic        busy_rs2,
    output logic        rf_we,
    output logic [4:0]  rf_wR,
    output logic [31:0] rf_wD
);

    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam int OW = (MAX_OUT < 1) ? 1 : $clog2(MAX_OUT + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [OW-1:0] OUT_LIM    = OW'(MAX_OUT);

    logic [4:0]    buf_wr_q [2];
    logic [31:0]   buf_wd_q [2];
    logic          rd_ptr_q, wr_ptr_q;
    logic [1:0]    count_q, count_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [OW-1:0] out_q, out_d;

    logic          empty_s, full_s, push_s, pop_s, forced_s, wb_take_s, issue_acc_s;
    logic [4:0]    head_wr_s;
    logic [31:0]   head_wd_s;
    logic          rd_busy_s;

`ifdef RF_WB_SCOREBOARD_EN
    logic [31:0]   busy_q, busy_d;

    assign rd_busy_s = busy_q[mc_rd];
    assign busy_rs1  = busy_q[rs1];
    assign busy_rs2  = busy_q[rs2];
`else
    logic          unused_s;

    assign unused_s  = ^{mc_rd, rs1, rs2};
    assign rd_busy_s = 1'b0;
    assign busy_rs1  = 1'b0;
    assign busy_rs2  = 1'b0;
`endif

    assign mc_ready    = !full_s;
    assign mc_issue_ok = (out_q < OUT_LIM) && !rd_busy_s;

    // Port arbitration; a forced head overrides WB, otherwise WB has priority.
    always_comb begin
        empty_s     = (count_q == 2'd0);
        full_s      = (count_q == 2'd2);
        head_wr_s   = buf_wr_q[rd_ptr_q];
        head_wd_s   = buf_wd_q[rd_ptr_q];
        forced_s    = !empty_s && (starve_q == STARVE_LIM);
        wb_take_s   = pipe_we && !forced_s;
        pop_s       = !empty_s && !wb_take_s;
        push_s      = mc_valid && !full_s;
        issue_acc_s = mc_issue && mc_issue_ok;
        pipe_hold   = rst_n && forced_s && pipe_we;
        rf_we       = 1'b0;
        rf_wR       = 5'd0;
        rf_wD       = 32'd0;
        // Reset gating keeps the write port quiet even if WB drives during reset.
        if (!rst_n) begin
            rf_we = 1'b0;
        end else if (wb_take_s) begin
            rf_we = (pipe_wr != 5'd0);
            rf_wR = pipe_wr;
            rf_wD = pipe_wd;
        end else if (pop_s) begin
            rf_we = (head_wr_s != 5'd0);
            rf_wR = head_wr_s;
            rf_wD = head_wd_s;
        end else begin
            rf_we = 1'b0;
        end
    end

    // Next-state for occupancy, starvation and outstanding counters.
    always_comb begin
        count_d  = count_q;
        starve_d = starve_q;
        out_d    = out_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        if (pop_s || empty_s) begin
            starve_d = {SW{1'b0}};
        end else if (wb_take_s && (starve_q != STARVE_LIM)) begin
            starve_d = starve_q + SW'(1);
        end else begin
            starve_d = starve_q;
        end
        // A stray result with nothing outstanding must not wrap the counter.
        case ({issue_acc_s, pop_s})
            2'b10:   out_d = out_q + OW'(1);
            2'b01:   out_d = (out_q != {OW{1'b0}}) ? out_q - OW'(1) : out_q;
            default: out_d = out_q;
        endcase
    end

`ifdef RF_WB_SCOREBOARD_EN
    // Scoreboard next-state: clear on matching pop, then set so set wins.
    always_comb begin
        busy_d = busy_q;
        if (pop_s && (head_wr_s != 5'd0)) begin
            busy_d[head_wr_s] = 1'b0;
        end else begin
            busy_d = busy_q;
        end
        if (issue_acc_s && (mc_rd != 5'd0)) begin
            busy_d[mc_rd] = 1'b1;
        end else begin
            busy_d[0] = 1'b0;
        end
        busy_d[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 32'd0;
        end else begin
            busy_q <= busy_d;
        end
    end
`endif

    // Buffer storage, pointers and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_wr_q[0] <= 5'd0;
            buf_wr_q[1] <= 5'd0;
            buf_wd_q[0] <= 32'd0;
            buf_wd_q[1] <= 32'd0;
            rd_ptr_q    <= 1'b0;
            wr_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
            starve_q    <= {SW{1'b0}};
            out_q       <= {OW{1'b0}};
        end else begin
            if (push_s) begin
                buf_wr_q[wr_ptr_q] <= mc_wr;
                buf_wd_q[wr_ptr_q] <= mc_wd;
                wr_ptr_q           <= ~wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q  <= count_d;
            starve_q <= starve_d;
            out_q    <= out_d;
        end
    end

endmodule

// File: tb/tb_rf_wb_sched.sv
// Directed self-checking bench for rf_wb_sched; expected busy values follow RF_WB_SCOREBOARD_EN.
module tb_rf_wb_sched;

`ifdef RF_WB_SCOREBOARD_EN
    localparam logic SB = 1'b1;
`else
    localparam logic SB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pipe_we;
    logic [4:0]  pipe_wr;
    logic [31:0] pipe_wd;
    logic        pipe_hold;
    logic        mc_issue;
    logic [4:0]  mc_rd;
    logic        mc_issue_ok;
    logic        mc_valid;
    logic        mc_ready;
    logic [4:0]  mc_wr;
    logic [31:0] mc_wd;
    logic [4:0]  rs1, rs2;
    logic        busy_rs1, busy_rs2;
    logic        rf_we;
    logic [4:0]  rf_wR;
    logic [31:0] rf_wD;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    rf_wb_sched #(.STARVE_MAX(3), .MAX_OUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .pipe_we(pipe_we), .pipe_wr(pipe_wr), .pipe_wd(pipe_wd), .pipe_hold(pipe_hold),
        .mc_issue(mc_issue), .mc_rd(mc_rd), .mc_issue_ok(mc_issue_ok),
        .mc_valid(mc_valid), .mc_ready(mc_ready), .mc_wr(mc_wr), .mc_wd(mc_wd),
        .rs1(rs1), .rs2(rs2), .busy_rs1(busy_rs1), .busy_rs2(busy_rs2),
        .rf_we(rf_we), .rf_wR(rf_wR), .rf_wD(rf_wD)
    );

    task automatic idle();
        pipe_we = 1'b0; pipe_wr = 5'd0; pipe_wd = 32'd0;
        mc_issue = 1'b0; mc_rd = 5'd0;
        mc_valid = 1'b0; mc_wr = 5'd0; mc_wd = 32'd0;
    endtask

    task automatic nc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; idle(); rs1 = 5'd0; rs2 = 5'd0;
        #2;
        pipe_we = 1'b1; pipe_wr = 5'd3; pipe_wd = 32'h1234;
        #1;
        n_chk++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_rf_we got=%0b exp=0", rf_we); end
        n_chk++; if (pipe_hold !== 1'b0) begin n_fail++; $display("FAIL reset_hold got=%0b exp=0", pipe_hold); end
        n_chk++; if (mc_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%0b exp=1", mc_ready); end
        n_chk++; if (mc_issue_ok !== 1'b1) begin n_fail++; $display("FAIL reset_issue_ok got=%0b exp=1", mc_issue_ok); end
        n_chk++; if ({busy_rs1, busy_rs2} !== 2'b00) begin n_fail++; $display("FAIL reset_busy got=%0b%0b exp=00", busy_rs1, busy_rs2); end
        idle();
        nc();
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        nc(); idle(); mc_valid = 1'b1; mc_wr = 5'd5; mc_wd = 32'hDEADBEEF; #2;
        n_chk++; if (mc_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready got=%0b exp=1", mc_ready); end
        n_chk++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL single_early_we got=%0b exp=0", rf_we); end
        nc(); idle(); #2;
        n_chk++; if (rf_we !== 1'b1) begin n_fail++; $display("FAIL single_we got=%0b exp=1", rf_we); end
        n_chk++; if (rf_wR !== 5'd5) begin n_fail++; $display("FAIL single_wR got=%0d exp=5", rf_wR); end
        n_chk++; if (rf_wD !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_wD got=%h exp=deadbeef", rf_wD); end
        nc(); #2;
        n_chk++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL single_empty_we got=%0b exp=0", rf_we); end
    endtask

    task automatic test_starve();
        nc(); idle(); pipe_we = 1'b1; pipe_wr = 5'd2; pipe_wd = 32'hA;
        mc_valid = 1'b1; mc_wr = 5'd9; mc_wd = 32'h11; #2;
        n_chk++; if (rf_wR !== 5'd2) begin n_fail++; $display("FAIL starve_first_wR got=%0d exp=2", rf_wR); end
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 3; k++) begin
                nc(); mc_valid = 1'b0; #2;
                n_chk++; if (rf_wR !== 5'd2) begin n_fail++; $display("FAIL starve_wb_wins_wR r%0d c%0d got=%0d exp=2", i, k, rf_wR); end
                n_chk++; if (pipe_hold !== 1'b0) begin n_fail++; $display("FAIL starve_wb_hold r%0d c%0d got=%0b exp=0", i, k, pipe_hold); end
            end
            nc(); #2;
            n_chk++; if (rf_wR !== (i == 0 ? 5'd9 : 5'd10)) begin n_fail++; $display("FAIL starve_forced_wR r%0d got=%0d", i, rf_wR); end
            n_chk++; if (rf_wD !== (i == 0 ? 32'h11 : 32'h22)) begin n_fail++; $display("FAIL starve_forced_wD r%0d got=%h", i, rf_wD); end
            n_chk++; if (pipe_hold !== 1'b1) begin n_fail++; $display("FAIL starve_forced_hold r%0d got=%0b exp=1", i, pipe_hold); end
            nc(); mc_valid = 1'b1; mc_wr = 5'd10; mc_wd = 32'h22; #2;
            n_chk++; if (pipe_hold !== 1'b0) begin n_fail++; $display("FAIL starve_after_hold r%0d got=%0b exp=0", i, pipe_hold); end
        end
        idle();
        nc(); #2;
        n_chk++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL starve_drained_we got=%0b exp=0", rf_we); end
    endtask

    task automatic test_back_to_back();
        nc(); idle(); pipe_we = 1'b1; pipe_wr = 5'd1; pipe_wd = 32'h5;
        mc_valid = 1'b1; mc_wr = 5'd11; mc_wd = 32'h1; #2;
        n_chk++; if (mc_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready0 got=%0b exp=1", mc_ready); end
        nc(); mc_wr = 5'd12; mc_wd = 32'h2; #2;
        n_chk++; if (mc_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready1 got=%0b exp=1", mc_ready); end
        nc(); mc_wr = 5'd13; mc_wd = 32'h3; #2;
        n_chk++; if (mc_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_full got=%0b exp=0", mc_ready); end
        nc(); #2;
        n_chk++; if (rf_wR !== 5'd1) begin n_fail++; $display("FAIL b2b_wb_wR got=%0d exp=1", rf_wR); end
        nc(); #2;
        n_chk++; if (rf_wR !== 5'd11 || rf_wD !== 32'h1) begin n_fail++; $display("FAIL b2b_head0 got=%0d/%h exp=11/1", rf_wR, rf_wD); end
        n_chk++; if (mc_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_on_pop got=%0b exp=0", mc_ready); end
        nc(); #2;
        n_chk++; if (mc_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_after_pop got=%0b exp=1", mc_ready); end
        nc(); idle(); #2;
        n_chk++; if (rf_wR !== 5'd12 || rf_wD !== 32'h2) begin n_fail++; $display("FAIL b2b_head1 got=%0d/%h exp=12/2", rf_wR, rf_wD); end
        nc(); #2;
        n_chk++; if (rf_wR !== 5'd13 || rf_wD !== 32'h3) begin n_fail++; $display("FAIL b2b_head2 got=%0d/%h exp=13/3", rf_wR, rf_wD); end
        nc(); #2;
        n_chk++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL b2b_drained got=%0b exp=0", rf_we); end
    endtask

    task automatic test_scoreboard();
        nc(); idle(); rs1 = 5'd7; rs2 = 5'd8; mc_issue = 1'b1; mc_rd = 5'd7; #2;
        n_chk++; if (mc_issue_ok !== 1'b1) begin n_fail++; $display("FAIL sb_issue_ok got=%0b exp=1", mc_issue_ok); end
        n_chk++; if (busy_rs1 !== 1'b0) begin n_fail++; $display("FAIL sb_busy_same_cycle got=%0b exp=0", busy_rs1); end
        nc(); idle(); mc_rd = 5'd7; pipe_we = 1'b1; pipe_wr = 5'd7; pipe_wd = 32'h55; #2;
        n_chk++; if (busy_rs1 !== SB) begin n_fail++; $display("FAIL sb_busy_set got=%0b exp=%0b", busy_rs1, SB); end
        n_chk++; if (busy_rs2 !== 1'b0) begin n_fail++; $display("FAIL sb_busy_rs2 got=%0b exp=0", busy_rs2); end
        n_chk++; if (mc_issue_ok !== !SB) begin n_fail++; $display("FAIL sb_issue_blocked got=%0b exp=%0b", mc_issue_ok, !SB); end
        nc(); idle(); mc_valid = 1'b1; mc_wr = 5'd7; mc_wd = 32'h77; #2;
        n_chk++; if (busy_rs1 !== SB) begin n_fail++; $display("FAIL sb_wb_no_clear got=%0b exp=%0b", busy_rs1, SB); end
        nc(); idle(); #2;
        n_chk++; if (rf_wR !== 5'd7 || rf_wD !== 32'h77) begin n_fail++; $display("FAIL sb_result got=%0d/%h exp=7/77", rf_wR, rf_wD); end
        n_chk++; if (busy_rs1 !== SB) begin n_fail++; $display("FAIL sb_busy_at_write got=%0b exp=%0b", busy_rs1, SB); end
        nc(); #2;
        n_chk++; if (busy_rs1 !== 1'b0) begin n_fail++; $display("FAIL sb_busy_cleared got=%0b exp=0", busy_rs1); end
        nc(); mc_valid = 1'b1; mc_wr = 5'd7; mc_wd = 32'h70; #2;
        nc(); idle(); mc_issue = 1'b1; mc_rd = 5'd7; #2;
        n_chk++; if (mc_issue_ok !== 1'b1 || rf_wR !== 5'd7) begin n_fail++; $display("FAIL sb_setclr_cycle got=%0b/%0d exp=1/7", mc_issue_ok, rf_wR); end
        nc(); idle(); mc_valid = 1'b1; mc_wr = 5'd7; mc_wd = 32'h71; #2;
        n_chk++; if (busy_rs1 !== SB) begin n_fail++; $display("FAIL sb_set_wins got=%0b exp=%0b", busy_rs1, SB); end
        nc(); idle(); #2;
        n_chk++; if (rf_wD !== 32'h71 || busy_rs1 !== SB) begin n_fail++; $display("FAIL sb_second_write got=%h/%0b", rf_wD, busy_rs1); end
        nc(); #2;
        n_chk++; if (busy_rs1 !== 1'b0) begin n_fail++; $display("FAIL sb_second_clear got=%0b exp=0", busy_rs1); end
    endtask

    task automatic test_outstanding();
        rs1 = 5'd2; rs2 = 5'd5;
        for (int i = 0; i < 4; i++) begin
            nc(); idle(); mc_issue = 1'b1; mc_rd = 5'(i + 1); #2;
            n_chk++; if (mc_issue_ok !== 1'b1) begin n_fail++; $display("FAIL out_issue%0d got=%0b exp=1", i, mc_issue_ok); end
        end
        nc(); idle(); mc_issue = 1'b1; mc_rd = 5'd5; #2;
        n_chk++; if (mc_issue_ok !== 1'b0) begin n_fail++; $display("FAIL out_limit got=%0b exp=0", mc_issue_ok); end
        nc(); idle(); mc_rd = 5'd5; mc_valid = 1'b1; mc_wr = 5'd1; mc_wd = 32'h1; #2;
        n_chk++; if (busy_rs2 !== 1'b0) begin n_fail++; $display("FAIL out_ignored_issue got=%0b exp=0", busy_rs2); end
        n_chk++; if (busy_rs1 !== SB) begin n_fail++; $display("FAIL out_busy2 got=%0b exp=%0b", busy_rs1, SB); end
        nc(); idle(); mc_rd = 5'd5; #2;
        n_chk++; if (rf_wR !== 5'd1 || mc_issue_ok !== 1'b0) begin n_fail++; $display("FAIL out_drain_cycle got=%0d/%0b exp=1/0", rf_wR, mc_issue_ok); end
        nc(); idle(); mc_issue = 1'b1; mc_rd = 5'd0; #2;
        n_chk++; if (mc_issue_ok !== 1'b1) begin n_fail++; $display("FAIL out_restored got=%0b exp=1", mc_issue_ok); end
        nc(); idle(); mc_rd = 5'd6; mc_valid = 1'b1; mc_wr = 5'd0; mc_wd = 32'h99; #2;
        n_chk++; if (mc_issue_ok !== 1'b0) begin n_fail++; $display("FAIL out_rd0_counted got=%0b exp=0", mc_issue_ok); end
        nc(); idle(); mc_rd = 5'd6; #2;
        n_chk++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL out_rd0_we got=%0b exp=0", rf_we); end
        n_chk++; if (busy_rs1 !== SB) begin n_fail++; $display("FAIL out_rd0_busy got=%0b exp=%0b", busy_rs1, SB); end
        nc(); mc_rd = 5'd6; #2;
        n_chk++; if (mc_issue_ok !== 1'b1) begin n_fail++; $display("FAIL out_rd0_decrement got=%0b exp=1", mc_issue_ok); end
    endtask

    task automatic test_reset_mid();
        rs1 = 5'd2;
        nc(); idle(); pipe_we = 1'b1; pipe_wr = 5'd3; pipe_wd = 32'h33;
        mc_valid = 1'b1; mc_wr = 5'd20; mc_wd = 32'hA0; #2;
        nc(); mc_wr = 5'd21; mc_wd = 32'hA1; #2;
        nc(); mc_valid = 1'b0; mc_rd = 5'd3; #2;
        n_chk++; if (mc_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_full got=%0b exp=0", mc_ready); end
        n_chk++; if (mc_issue_ok !== !SB) begin n_fail++; $display("FAIL rstmid_pre_ok got=%0b exp=%0b", mc_issue_ok, !SB); end
        #1; rst_n = 1'b0; #1;
        n_chk++; if (rf_we !== 1'b0 || pipe_hold !== 1'b0) begin n_fail++; $display("FAIL rstmid_port got=%0b/%0b exp=0/0", rf_we, pipe_hold); end
        n_chk++; if (mc_ready !== 1'b1 || mc_issue_ok !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready got=%0b/%0b exp=1/1", mc_ready, mc_issue_ok); end
        n_chk++; if (busy_rs1 !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got=%0b exp=0", busy_rs1); end
        nc(); idle();
        nc(); rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            nc(); #2;
            n_chk++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_write c%0d got=%0b exp=0", i, rf_we); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_starve();
        test_back_to_back();
        test_scoreboard();
        test_outstanding();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
